// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory stream reader.
// Holds the data-memory geometry (kept in step with the data memory itself),
// the derived word-index and word-count widths, the reader state encoding,
// and a helper that turns a word index into a word-aligned byte address.
package dmem_pkg;

  localparam int DATA_BIT_WIDTH = 32;
  localparam int DMEMADDRBITS   = 13;
  localparam int DMEMWORDBITS   = 2;
  localparam int DMEMWORDS      = 2048;

  localparam int IDXW = DMEMADDRBITS - DMEMWORDBITS;
  localparam int CNTW = IDXW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    PRIME  = 2'd2,
    STREAM = 2'd3
  } state_t;

  // Word index placed in the decoded byte-address field; every other bit is 0.
  function automatic logic [DATA_BIT_WIDTH-1:0] word_to_byte_addr(input logic [IDXW-1:0] idx);
    logic [DATA_BIT_WIDTH-1:0] a;
    a = '0;
    a[DMEMADDRBITS-1:DMEMWORDBITS] = idx;
    return a;
  endfunction

endpackage

// File: rtl/dmem_stream_reader.sv
// Sequential read engine for the registered-address data memory.
// Reads `count` consecutive words starting at the word addressed by
// `startAddr` and presents them in order on a valid/ready stream.
//
// Ports:
//   clk        single clock, all state on posedge
//   reset      asynchronous, active-low
//   start      request, sampled only while idle
//   startAddr  byte address of the first word
//   count      number of words (0 gives an immediate done pulse)
//   abort      synchronous cancel of a run in progress, no done pulse
//   memAddr    byte address to the data memory
//   memData    data memory read data (address registered at previous edge)
//   outData    stream word
//   outValid   stream word valid
//   outReady   consumer accepts; transfer = outValid & outReady
//   busy       high whenever a run is in progress
//   done       one-cycle pulse after the final transfer
//
// state  | meaning
// IDLE   | waiting for start; memAddr parked on idx
// FETCH  | first word address presented to memory
// PRIME  | first word arriving; next address presented
// STREAM | outValid high; one word per accepted transfer
module dmem_stream_reader
  import dmem_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DATA_BIT_WIDTH-1:0] startAddr,
  input  logic [CNTW-1:0]           count,
  input  logic                      abort,
  output logic [DATA_BIT_WIDTH-1:0] memAddr,
  input  logic [DATA_BIT_WIDTH-1:0] memData,
  output logic [DATA_BIT_WIDTH-1:0] outData,
  output logic                      outValid,
  input  logic                      outReady,
  output logic                      busy,
  output logic                      done
);

  state_t          state;
  logic [IDXW-1:0] idx;
  logic [CNTW-1:0] rem;
  logic [IDXW-1:0] addr_idx;
  logic            xfer;
  logic            last_word;

  // Only the decoded word-index field of the start address is meaningful.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{startAddr[DATA_BIT_WIDTH-1:DMEMADDRBITS],
                              startAddr[DMEMWORDBITS-1:0]};

  assign xfer      = outValid & outReady;
  assign last_word = (rem == CNTW'(1));
  assign busy      = (state != IDLE);

  // On an accepted non-final transfer the memory must already be fetching
  // the word after idx so that memData lines up with the advanced idx next
  // cycle; otherwise keep re-reading idx so memData stays valid across stalls.
  always_comb begin
    addr_idx = idx;
    if (state == STREAM && xfer && !last_word) begin
      addr_idx = idx + 1'b1;
    end
  end

  assign memAddr = word_to_byte_addr(addr_idx);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      rem      <= '0;
      outData  <= '0;
      outValid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      // abort beats a same-cycle transfer; the consumer still took that word.
      if (abort && state != IDLE) begin
        state    <= IDLE;
        outValid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (count == '0) begin
                done <= 1'b1;
              end else begin
                idx   <= startAddr[DMEMADDRBITS-1:DMEMWORDBITS];
                rem   <= count;
                state <= FETCH;
              end
            end
          end
          FETCH: begin
            idx   <= idx + 1'b1;
            state <= PRIME;
          end
          PRIME: begin
            outData  <= memData;
            outValid <= 1'b1;
            state    <= STREAM;
          end
          STREAM: begin
            if (xfer) begin
              if (last_word) begin
                outValid <= 1'b0;
                done     <= 1'b1;
                state    <= IDLE;
              end else begin
                outData <= memData;
                idx     <= idx + 1'b1;
                rem     <= rem - 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/dmem_stream_reader.md
# dmem_stream_reader

Sequential read engine for data memory. It reads a run of consecutive words from the registered-address data memory and presents them, in order, on a valid/ready output stream. It sits between the memory's read port and any consumer that needs bulk data: debug dump, block copy, or the load path. After a one-word prime it sustains one word per cycle while the consumer accepts.

## Interface
- DATA_BIT_WIDTH, 32, data and byte-address width
- DMEMADDRBITS, 13, byte-address bits decoded by data memory
- DMEMWORDBITS, 2, byte-offset bits within a word
- DMEMWORDS, 2048, words in data memory (= 2^(DMEMADDRBITS-DMEMWORDBITS))
- Derived: IDXW = DMEMADDRBITS-DMEMWORDBITS (word-index width); CNTW = IDXW+1
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low (0 = in reset)
- start  in  1  request; sampled only in IDLE
- startAddr  in  DATA_BIT_WIDTH  byte address of first word; bits [DMEMADDRBITS-1:DMEMWORDBITS] used
- count  in  CNTW  number of words, 0..DMEMWORDS
- abort  in  1  synchronous cancel
- memAddr  out  DATA_BIT_WIDTH  byte address to memory; word index in [DMEMADDRBITS-1:DMEMWORDBITS], all other bits 0
- memData  in  DATA_BIT_WIDTH  memory read data; reflects memAddr sampled at the previous posedge
- outData  out  DATA_BIT_WIDTH  stream word
- outValid  out  1  outData valid
- outReady  in  1  consumer accepts; transfer = outValid & outReady
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the final transfer

## Operation
- States: IDLE, FETCH, PRIME, STREAM.
- IDLE: start=1 with count=0 leads to a done pulse next cycle and stays in IDLE. start=1 with count>0 loads idx=startAddr word index, rem=count, and goes to FETCH.
- FETCH: memAddr=idx. Then idx<=idx+1 and go to PRIME.
- PRIME: memAddr=idx. Then outData<=memData, outValid<=1, and go to STREAM.
- STREAM, memAddr is combinational:
  - Transfer and rem>1: memAddr=idx+1; outData<=memData; idx<=idx+1; rem<=rem-1.
  - No transfer: memAddr=idx; outData, idx and rem hold.
  - Transfer and rem==1: outValid<=0, done<=1, go to IDLE.
- The memory's one-cycle registered-address latency guarantees memData equals word idx in every STREAM cycle.
- Index arithmetic is modulo DMEMWORDS. Wrap from DMEMWORDS-1 to 0 is silent and is not an error.
- start outside IDLE is ignored. abort in any non-IDLE state goes to IDLE next cycle; outValid and busy go 0; no done pulse. abort in IDLE has no effect. abort has priority over a same-cycle transfer; that transfer still counts as accepted by the consumer.
- Output stability: while outValid=1 and outReady=0, outData holds.

## Timing
- Reset values: state=IDLE, outValid=0, outData=0, busy=0, done=0, memAddr=0, idx=0, rem=0. Reset mid-stream drops everything immediately (asynchronously); no done pulse.
- start sampled at edge 0 leads to FETCH in cycle 1, PRIME in cycle 2, and first outValid in cycle 3. First-word latency is 3 cycles.
- With outReady held high, words flow one per cycle. The last transfer in cycle N gives done=1 in cycle N+1 with outValid=0.
- done is high exactly one cycle. A new start is accepted in the done cycle, since the state is IDLE.

## Structure
- Shared package (dmem_pkg):
  - state enum (IDLE/FETCH/PRIME/STREAM, 2-bit encoding)
  - the DMEM* width constants shared with the data memory
  - IDXW/CNTW derivations
- Single flat module. No sub-module is required; the index/remaining counter pair stays inline.

## Test plan
- Memory preloaded with word i = 0x1000+i. start, startAddr=0x10, count=4, outReady=1 -> outValid cycles 3..6 carry 0x1004..0x1007; done in cycle 7; busy cycles 1..6.
- Same run, outReady toggling 1,0,0,1,0,1… -> each word appears exactly once, in order; outData stable during stalls; no drops or duplicates.
- startAddr=(DMEMWORDS-2)*4, count=4 -> words DMEMWORDS-2, DMEMWORDS-1, 0, 1; memAddr wraps to 0.
- count=0 -> done pulse the cycle after start; outValid never asserted; busy stays 0.
- abort in the second STREAM cycle of a count=8 run -> next cycle outValid=0, busy=0, no done; a following start streams correctly from its new startAddr.
- reset deasserted-then-asserted (driven 0) mid-STREAM -> all outputs 0 immediately without a clock edge; after release, IDLE; start runs normally.
